regfile_write_scheduler: RTL

Schedules the single write port of the 32×32 register file between the in-order pipeline writeback (A) and a long-latency unit (B: multiply/divide or load-miss return). It holds a pending-write scoreboard that stalls decode on RAW/WAW hazards against in-flight B results. A bounded-wait hold request guarantees B is never starved. It sits between the writeback stage and the register file write inputs (we, rd, write_data).

---
 rtl/regfile_write_scheduler.sv | 99 +++++++++
 1 files changed

// File: rtl/regfile_write_scheduler.sv
// Register file write-port arbiter: pipeline writeback (A) over long-latency results (B),
// with a pending-write scoreboard for decode hazards and a bounded-wait hold for B.
module regfile_write_scheduler #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        dec_stall,
  output logic        hold_pipe,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy_vec
);

  localparam int unsigned CW = 4;
  localparam logic [CW:0] MAX_W = MAX_WAIT[CW:0];

  logic          src_b_q;
  logic [CW-1:0] wait_cnt;
  logic [CW:0]   wait_inc;
  logic [CW-1:0] wait_next;
  logic          b_take;
  logic          b_refused;
  logic          hold_next;
  logic [31:0]   busy_q;
  logic [31:0]   busy_next;

  assign b_take    = b_valid && !a_valid;
  assign b_refused = b_valid && a_valid;
  assign b_ready   = b_take;

  assign wait_inc  = {1'b0, wait_cnt} + {{CW{1'b0}}, 1'b1};

  // Hold is raised on the edge where the refusal count reaches MAX_WAIT, and
  // re-raised every further refused cycle while the count stays saturated.
  assign hold_next = b_refused && (wait_inc >= MAX_W);

  always_comb begin
    wait_next = '0;
    if (b_refused) begin
      if ({1'b0, wait_cnt} >= MAX_W) wait_next = wait_cnt;
      else                           wait_next = wait_inc[CW-1:0];
    end
  end

  // Set beats clear when the same register issues as its B result retires.
  always_comb begin
    busy_next = busy_q;
    if (rf_we && src_b_q) busy_next[rf_rd] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  assign busy_vec  = busy_q;
  assign dec_stall = dec_valid && (busy_q[dec_rs1] || busy_q[dec_rs2] || busy_q[dec_rd]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_rd     <= 5'd0;
      rf_wdata  <= 32'd0;
      src_b_q   <= 1'b0;
      wait_cnt  <= '0;
      hold_pipe <= 1'b0;
      busy_q    <= 32'd0;
    end else begin
      if (a_valid) begin
        rf_we    <= (a_rd != 5'd0);
        rf_rd    <= a_rd;
        rf_wdata <= a_data;
      end else if (b_take) begin
        rf_we    <= (b_rd != 5'd0);
        rf_rd    <= b_rd;
        rf_wdata <= b_data;
      end else begin
        rf_we    <= 1'b0;
      end
      src_b_q   <= b_take;
      wait_cnt  <= wait_next;
      hold_pipe <= hold_next;
      busy_q    <= busy_next;
    end
  end

endmodule
